game_sequencer: RTL and testbench

Top-level game-flow controller for breakout: it sequences serve, play, life loss, game over and win, and owns the 208-bit block-state register that feeds the blocks painter. It sits between the VGA timing/collision logic and `ball_logic`. It gates ball motion (`do_move`), requests ball re-centring (`ball_reset`), and removes blocks on hit. Lives and score are kept here for the overlay/debug outputs.

---
 rtl/breakout_pkg.sv | 40 ++++
 rtl/game_sequencer_select_edge.sv | 64 ++++++
 rtl/game_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_game_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// ----------------------------------------------------------------------------
// breakout_pkg
// Shared definitions for the breakout game-flow controller:
//   - game FSM state encoding (also exported on the debug `state` port)
//   - block field geometry (16 rows x 13 columns = 208 blocks)
//   - BLOCK_INIT: checkerboard start field, block r*13+c present iff (r+c) odd
// ----------------------------------------------------------------------------
package breakout_pkg;

   localparam int NUM_BLOCKS = 208;
   localparam int BLOCK_ROWS = 16;
   localparam int BLOCK_COLS = 13;

   // Number of blocks present in BLOCK_INIT (half of the checkerboard).
   localparam logic [6:0] BLOCK_COUNT_INIT = 7'd104;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_DEATH     = 3'd3,
      ST_GAME_OVER = 3'd4,
      ST_WIN       = 3'd5
   } game_state_e;

   // Build the checkerboard start field at elaboration time.
   function automatic logic [NUM_BLOCKS-1:0] block_init_f();
      logic [NUM_BLOCKS-1:0] v;
      v = '0;
      for (int r = 0; r < BLOCK_ROWS; r++) begin
         for (int c = 0; c < BLOCK_COLS; c++) begin
            v[r*BLOCK_COLS + c] = (((r + c) % 2) != 0);
         end
      end
      return v;
   endfunction

   localparam logic [NUM_BLOCKS-1:0] BLOCK_INIT = block_init_f();

endpackage

// File: rtl/game_sequencer_select_edge.sv
// ----------------------------------------------------------------------------
// select_edge
// Turns the raw asynchronous select button into a one-cycle `sel` event.
// The button is brought into the clk domain by a 2-flop synchronizer and is
// sampled only on frame_pulse cycles, which debounces it at frame rate.
// `sel` fires on a frame_pulse cycle whose sample is 1 while the previous
// sample was 0. With en low every flop holds and no sample is taken.
// Ports:
//   clk, nRst    : pixel clock, asynchronous active-low reset
//   en           : global enable
//   frame_pulse  : one-cycle pulse per frame
//   btn_select   : raw button (asynchronous)
//   sel          : one-cycle rising-edge event (combinational, same cycle
//                  as the frame_pulse that detects it)
// ----------------------------------------------------------------------------
module select_edge (
   input  logic clk,
   input  logic nRst,
   input  logic en,
   input  logic frame_pulse,
   input  logic btn_select,
   output logic sel
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic sample_q, sample_d;

   // Synchronizer and frame-rate sample registers.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         sample_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         sample_q <= sample_d;
      end
   end

   // Next-state: shift the synchronizer and take a sample on frame pulses.
   always_comb begin
      sync1_d  = sync1_q;
      sync2_d  = sync2_q;
      sample_d = sample_q;
      if (en) begin
         sync1_d = btn_select;
         sync2_d = sync1_q;
         if (frame_pulse) begin
            sample_d = sync2_q;
         end else begin
            sample_d = sample_q;
         end
      end else begin
         sync1_d  = sync1_q;
         sync2_d  = sync2_q;
         sample_d = sample_q;
      end
   end

   assign sel = en & frame_pulse & sync2_q & ~sample_q;

endmodule

// File: rtl/game_sequencer.sv
// ----------------------------------------------------------------------------
// game_sequencer
// Breakout game-flow controller: IDLE -> SERVE -> PLAY -> (DEATH -> SERVE |
// GAME_OVER) or WIN, owning the 208-bit block-state register, the remaining
// block count, lives, death timer and (optionally) the score.
// Parameters:
//   LIVES        : lives loaded at game start (1..3)
//   DEATH_FRAMES : frame pulses spent in DEATH (1..255)
// Ports:
//   clk, nRst           : pixel clock, asynchronous active-low reset
//   en                  : low -> all registers hold, do_move = 0
//   frame_pulse         : one-cycle pulse per frame
//   btn_select          : raw select button
//   block_hit/_idx      : ball touched block idx (row*13+col)
//   ball_lost           : ball passed the bottom edge
//   block_state         : bit i = block i present
//   do_move, ball_reset : ball motion gate / hold ball at serve position
//   lives, score, state : overlay / debug
// Configuration macro: GAME_SCORE_EN -- when defined, a 10-bit saturating
// score counter is built; otherwise `score` is tied to 0.
// ----------------------------------------------------------------------------
module game_sequencer
   import breakout_pkg::*;
#(
   parameter int LIVES        = 3,
   parameter int DEATH_FRAMES = 60
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic                  en,
   input  logic                  frame_pulse,
   input  logic                  btn_select,
   input  logic                  block_hit,
   input  logic [7:0]            block_hit_idx,
   input  logic                  ball_lost,
   output logic [NUM_BLOCKS-1:0] block_state,
   output logic                  do_move,
   output logic                  ball_reset,
   output logic [1:0]            lives,
   output logic [9:0]            score,
   output logic [2:0]            state
);

   localparam logic [1:0] LIVES_INIT = 2'(LIVES);
   localparam logic [7:0] DEATH_INIT = 8'(DEATH_FRAMES);

   game_state_e           state_q, state_d;
   logic [NUM_BLOCKS-1:0] block_q, block_d;
   logic [6:0]            count_q, count_d;
   logic [1:0]            lives_q, lives_d;
   logic [7:0]            timer_q, timer_d;
   logic                  sel;
   logic                  hit_valid;
`ifdef GAME_SCORE_EN
   logic [9:0]            score_q, score_d;
`endif

   select_edge u_select_edge (
      .clk         (clk),
      .nRst        (nRst),
      .en          (en),
      .frame_pulse (frame_pulse),
      .btn_select  (btn_select),
      .sel         (sel)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         block_q <= BLOCK_INIT;
         count_q <= BLOCK_COUNT_INIT;
         lives_q <= LIVES_INIT;
         timer_q <= 8'd0;
`ifdef GAME_SCORE_EN
         score_q <= 10'd0;
`endif
      end else begin
         state_q <= state_d;
         block_q <= block_d;
         count_q <= count_d;
         lives_q <= lives_d;
         timer_q <= timer_d;
`ifdef GAME_SCORE_EN
         score_q <= score_d;
`endif
      end
   end

   // Next-state and datapath updates; nothing moves while en is low.
   always_comb begin
      state_d   = state_q;
      block_d   = block_q;
      count_d   = count_q;
      lives_d   = lives_q;
      timer_d   = timer_q;
`ifdef GAME_SCORE_EN
      score_d   = score_q;
`endif
      // Out-of-range indices never reach the bit select (short-circuit).
      hit_valid = block_hit && (block_hit_idx < 8'd208) && block_q[block_hit_idx];

      if (en) begin
         case (state_q)
            ST_IDLE: begin
               if (sel) begin
                  state_d = ST_SERVE;
                  block_d = BLOCK_INIT;
                  count_d = BLOCK_COUNT_INIT;
                  lives_d = LIVES_INIT;
`ifdef GAME_SCORE_EN
                  score_d = 10'd0;
`endif
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SERVE: begin
               if (sel) begin
                  state_d = ST_PLAY;
               end else begin
                  state_d = ST_SERVE;
               end
            end
            ST_PLAY: begin
               if (hit_valid) begin
                  block_d[block_hit_idx] = 1'b0;
                  count_d = count_q - 7'd1;
`ifdef GAME_SCORE_EN
                  if (score_q != 10'd1023) begin
                     score_d = score_q + 10'd1;
                  end else begin
                     score_d = score_q;
                  end
`endif
               end else begin
                  block_d = block_q;
               end
               // Clearing the last block wins even if the ball is lost
               // in the same cycle.
               if (hit_valid && (count_q == 7'd1)) begin
                  state_d = ST_WIN;
               end else if (ball_lost) begin
                  state_d = ST_DEATH;
                  timer_d = DEATH_INIT;
                  if (lives_q != 2'd0) begin
                     lives_d = lives_q - 2'd1;
                  end else begin
                     lives_d = 2'd0;
                  end
               end else begin
                  state_d = ST_PLAY;
               end
            end
            ST_DEATH: begin
               // Leave on the DEATH_FRAMES-th frame pulse after entry.
               if (frame_pulse) begin
                  if (timer_q <= 8'd1) begin
                     timer_d = 8'd0;
                     if (lives_q == 2'd0) begin
                        state_d = ST_GAME_OVER;
                     end else begin
                        state_d = ST_SERVE;
                     end
                  end else begin
                     timer_d = timer_q - 8'd1;
                  end
               end else begin
                  timer_d = timer_q;
               end
            end
            ST_GAME_OVER, ST_WIN: begin
               if (sel) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = state_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Output decode from registered state.
   always_comb begin
      do_move    = 1'b0;
      ball_reset = 1'b0;
      case (state_q)
         ST_IDLE, ST_SERVE: begin
            ball_reset = 1'b1;
         end
         ST_PLAY: begin
            do_move = en;
         end
         default: begin
            do_move    = 1'b0;
            ball_reset = 1'b0;
         end
      endcase
   end

   assign block_state = block_q;
   assign lives       = lives_q;
   assign state       = state_q;
`ifdef GAME_SCORE_EN
   assign score       = score_q;
`else
   assign score       = 10'd0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// ----------------------------------------------------------------------------
// tb_game_sequencer
// Self-checking bench for game_sequencer: a table of directed vectors, a few
// hand-written multi-cycle sequences and a randomized run, all compared every
// cycle against a behavioural game model kept in the bench.
// ----------------------------------------------------------------------------
module tb_game_sequencer;

   logic         clk = 1'b0;
   logic         nRst;
   logic         en;
   logic         frame_pulse;
   logic         btn_select;
   logic         block_hit;
   logic [7:0]   block_hit_idx;
   logic         ball_lost;
   logic [207:0] block_state;
   logic         do_move;
   logic         ball_reset;
   logic [1:0]   lives;
   logic [9:0]   score;
   logic [2:0]   state;

`ifdef GAME_SCORE_EN
   localparam bit SCORE_ON = 1'b1;
`else
   localparam bit SCORE_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   game_sequencer dut (
      .clk           (clk),
      .nRst          (nRst),
      .en            (en),
      .frame_pulse   (frame_pulse),
      .btn_select    (btn_select),
      .block_hit     (block_hit),
      .block_hit_idx (block_hit_idx),
      .ball_lost     (ball_lost),
      .block_state   (block_state),
      .do_move       (do_move),
      .ball_reset    (ball_reset),
      .lives         (lives),
      .score         (score),
      .state         (state)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural model ----------------
   int m_state, m_lives, m_score, m_frames_left;
   bit m_blk[208];
   bit m_prev_sample;
   bit btn_hist[$];   // button level at each enabled clock edge

   function automatic bit init_present(int i);
      return (((i / 13) + (i % 13)) % 2) == 1;
   endfunction

   function automatic logic [207:0] init_vec();
      logic [207:0] v;
      for (int i = 0; i < 208; i++) v[i] = init_present(i);
      return v;
   endfunction

   function automatic int remaining();
      int n = 0;
      for (int i = 0; i < 208; i++) n += int'(m_blk[i]);
      return n;
   endfunction

   function automatic logic [207:0] model_vec();
      logic [207:0] v;
      for (int i = 0; i < 208; i++) v[i] = m_blk[i];
      return v;
   endfunction

   function automatic void model_reset();
      m_state = 0; m_lives = 3; m_score = 0; m_frames_left = 0;
      for (int i = 0; i < 208; i++) m_blk[i] = init_present(i);
      m_prev_sample = 1'b0;
      btn_hist.delete();
   endfunction

   // One clock edge of game rules, given the inputs present before the edge.
   function automatic void model_edge(bit e, bit f, bit b, bit h, int idx, bit l);
      bit synced, sel, won;
      if (!e) return;
      // button seen through two synchronizer stages = level two edges ago
      synced = (btn_hist.size() >= 2) ? btn_hist[btn_hist.size()-2] : 1'b0;
      btn_hist.push_back(b);
      sel = f && synced && !m_prev_sample;
      if (f) m_prev_sample = synced;
      case (m_state)
         0: if (sel) begin
               m_state = 1; m_lives = 3; m_score = 0;
               for (int i = 0; i < 208; i++) m_blk[i] = init_present(i);
            end
         1: if (sel) m_state = 2;
         2: begin
               won = 1'b0;
               if (h && idx < 208 && m_blk[idx]) begin
                  m_blk[idx] = 1'b0;
                  m_score = (m_score < 1023) ? m_score + 1 : 1023;
                  won = (remaining() == 0);
               end
               if (won) m_state = 5;
               else if (l) begin
                  m_state = 3;
                  m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                  m_frames_left = 60;
               end
            end
         3: if (f) begin
               m_frames_left--;
               if (m_frames_left == 0) m_state = (m_lives == 0) ? 4 : 1;
            end
         default: if (sel) m_state = 0;
      endcase
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [207:0] act, input logic [207:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic compare_model();
      chk("state",       208'(state),      208'(m_state));
      chk("lives",       208'(lives),      208'(m_lives));
      chk("score",       208'(score),      SCORE_ON ? 208'(m_score) : 208'(0));
      chk("do_move",     208'(do_move),    208'((m_state == 2) && en));
      chk("ball_reset",  208'(ball_reset), 208'((m_state == 0) || (m_state == 1)));
      chk("block_state", block_state,      model_vec());
   endtask

   task automatic step(input bit e, input bit f, input bit b, input bit h,
                       input logic [7:0] idx, input bit l);
      en = e; frame_pulse = f; btn_select = b; block_hit = h;
      block_hit_idx = idx; ball_lost = l;
      model_edge(e, f, b, h, int'(idx), l);
      @(posedge clk); #1;
      compare_model();
   endtask

   // Asynchronous reset mid-cycle; outputs must return to reset values at once.
   task automatic async_reset();
      en = 1'b1; frame_pulse = 1'b0; btn_select = 1'b0; block_hit = 1'b0;
      block_hit_idx = 8'd0; ball_lost = 1'b0;
      #2 nRst = 1'b0;
      model_reset();
      #1;
      chk("rst_state",      208'(state),      208'(0));
      chk("rst_lives",      208'(lives),      208'(3));
      chk("rst_score",      208'(score),      208'(0));
      chk("rst_do_move",    208'(do_move),    208'(0));
      chk("rst_ball_reset", 208'(ball_reset), 208'(1));
      chk("rst_blocks",     block_state,      init_vec());
      en = 1'b0;
      @(posedge clk); #3 nRst = 1'b1;
      @(posedge clk); #1;
   endtask

   // Press and release select so that exactly one sel event occurs.
   task automatic press();
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit en, fp, btn, hit; logic [7:0] idx; bit lost;
      int probe; int e_state, e_lives, e_score; bit e_move, e_bit;
   } vec_t;

   function automatic vec_t mk(bit e, bit f, bit b, bit h, int idx, bit l,
                               int p, int st, int lv, int sc, bit mv, bit bt);
      vec_t v;
      v.en = e; v.fp = f; v.btn = b; v.hit = h; v.idx = 8'(idx); v.lost = l;
      v.probe = p; v.e_state = st; v.e_lives = lv; v.e_score = sc;
      v.e_move = mv; v.e_bit = bt;
      return v;
   endfunction

   vec_t tbl[18];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int frames, guard, last_idx;
      bit lvl;

      //          en fp btn hit idx lost probe st lv sc mv bit
      tbl[0]  = mk(1, 0, 1, 0,   0, 0,  1, 0, 3, 0, 0, 1);
      tbl[1]  = mk(1, 0, 1, 0,   0, 0,  1, 0, 3, 0, 0, 1);
      tbl[2]  = mk(1, 1, 1, 0,   0, 0,  1, 1, 3, 0, 0, 1);
      tbl[3]  = mk(1, 1, 0, 0,   0, 0,  1, 1, 3, 0, 0, 1);
      tbl[4]  = mk(1, 1, 0, 0,   0, 0,  1, 1, 3, 0, 0, 1);
      tbl[5]  = mk(1, 1, 0, 0,   0, 0,  1, 1, 3, 0, 0, 1);
      tbl[6]  = mk(1, 0, 1, 0,   0, 0,  1, 1, 3, 0, 0, 1);
      tbl[7]  = mk(1, 0, 1, 0,   0, 0,  1, 1, 3, 0, 0, 1);
      tbl[8]  = mk(1, 1, 1, 0,   0, 0,  1, 2, 3, 0, 1, 1);
      tbl[9]  = mk(1, 0, 0, 1,   1, 0,  1, 2, 3, 1, 1, 0);
      tbl[10] = mk(1, 0, 0, 1,   1, 0,  1, 2, 3, 1, 1, 0);
      tbl[11] = mk(1, 0, 0, 1,   0, 0,  0, 2, 3, 1, 1, 0);
      tbl[12] = mk(1, 0, 0, 1, 250, 0,  3, 2, 3, 1, 1, 1);
      tbl[13] = mk(1, 0, 0, 1,  13, 0, 13, 2, 3, 2, 1, 0);
      tbl[14] = mk(0, 1, 0, 1,   3, 0,  3, 2, 3, 2, 0, 1);
      tbl[15] = mk(1, 0, 0, 1,   3, 0,  3, 2, 3, 3, 1, 0);
      tbl[16] = mk(1, 0, 0, 0,   0, 1,  5, 3, 2, 3, 0, 1);
      tbl[17] = mk(1, 1, 0, 0,   0, 0,  5, 3, 2, 3, 0, 1);

      nRst = 1'b1;
      async_reset();

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].en, tbl[i].fp, tbl[i].btn, tbl[i].hit, tbl[i].idx, tbl[i].lost);
         chk($sformatf("tbl%0d_state", i), 208'(state), 208'(tbl[i].e_state));
         chk($sformatf("tbl%0d_lives", i), 208'(lives), 208'(tbl[i].e_lives));
         chk($sformatf("tbl%0d_score", i), 208'(score),
             SCORE_ON ? 208'(tbl[i].e_score) : 208'(0));
         chk($sformatf("tbl%0d_move", i),  208'(do_move), 208'(tbl[i].e_move));
         chk($sformatf("tbl%0d_bit", i),   208'(block_state[tbl[i].probe]),
             208'(tbl[i].e_bit));
      end

      // Reset during DEATH.
      async_reset();

      // Three lives lost, each DEATH lasting 60 frames, then GAME_OVER.
      press();
      chk("serve_state", 208'(state), 208'(1));
      chk("serve_blocks", block_state, init_vec());
      for (int life = 0; life < 3; life++) begin
         press();
         chk("play_state", 208'(state), 208'(2));
         step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
         chk("death_state", 208'(state), 208'(3));
         chk("death_lives", 208'(lives), 208'(2 - life));
         frames = 0; guard = 0;
         while (state == 3'd3 && guard < 1000) begin
            if (guard % 2 == 1) frames++;
            step(1'b1, 1'(guard % 2), 1'b0, 1'b0, 8'd0, 1'b0);
            guard++;
         end
         chk("death_frames", 208'(frames), 208'(60));
         chk("after_death", 208'(state), (life < 2) ? 208'(1) : 208'(4));
      end
      press();
      chk("gameover_to_idle", 208'(state), 208'(0));

      // en low in PLAY freezes everything.
      async_reset();
      press(); press();
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 1'(k == 2));
         chk("enlow_move",  208'(do_move),        208'(0));
         chk("enlow_state", 208'(state),          208'(2));
         chk("enlow_bit5",  208'(block_state[5]), 208'(1));
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0);
      chk("resume_bit5", 208'(block_state[5]), 208'(0));
      chk("resume_move", 208'(do_move),        208'(1));
      // reset in DEATH after a few frames
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      chk("pre_reset_death", 208'(state), 208'(3));
      async_reset();

      // Clear the whole field; last hit coincides with ball_lost.
      press(); press();
      last_idx = 207;
      for (int i = 0; i < last_idx; i++) begin
         if (init_present(i)) step(1'b1, 1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
      end
      chk("prewin_state", 208'(state), 208'(2));
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'(last_idx), 1'b1);
      chk("win_state", 208'(state), 208'(5));
      chk("win_lives", 208'(lives), 208'(3));
      chk("win_score", 208'(score), SCORE_ON ? 208'(104) : 208'(0));
      press();
      chk("win_to_idle",   208'(state),  208'(0));
      chk("field_held",    block_state,  208'(0));

      // Randomized play against the model.
      async_reset();
      lvl = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         if ($urandom_range(0, 19) == 0) lvl = ~lvl;
         step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) == 0), lvl,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(0, 207)),
              1'($urandom_range(0, 149) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
